// File: rtl/imem_fetch_ctrl_if.sv
// Bus between the fetch controller, the instruction ROM and the decode stage.
// The slave side is the fetch controller; fsm_state is a debug view of its FSM.
interface imem_fetch_ctrl_if #(
  parameter int N     = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 6
);
  // Handshake: decode pulls the head entry by raising deq in any cycle where
  // instr_valid=1; deq with instr_valid=0 is ignored, and redirect wins over deq.
  logic                     enable;
  logic                     redirect;
  logic [63:0]              redirect_pc;
  logic                     deq;
  logic [N-1:0]             imem_q;
  logic [AW-1:0]            imem_addr;
  logic                     instr_valid;
  logic [N-1:0]             instr;
  logic [63:0]              instr_pc;
  logic [$clog2(DEPTH):0]   count;
  logic                     done;
  logic [1:0]               fsm_state;

  modport slave (
    input  enable, redirect, redirect_pc, deq, imem_q,
    output imem_addr, instr_valid, instr, instr_pc, count, done, fsm_state
  );

  modport master (
    output enable, redirect, redirect_pc, deq, imem_q,
    input  imem_addr, instr_valid, instr, instr_pc, count, done, fsm_state
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, reads the ROM combinationally
// and buffers {instr, pc} pairs in a small FIFO for the decode stage.
module imem_fetch_ctrl #(
  parameter int N     = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 6
) (
  input  logic              clk,
  input  logic              reset,
  imem_fetch_ctrl_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
  localparam logic [63:0]   LAST_PC = 64'(4 * ((2 ** AW) - 1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [63:0]    fetch_pc;
  logic [PW-1:0]  head, tail;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   mem_instr [DEPTH];
  logic [63:0]    mem_pc    [DEPTH];

  logic           enq, deq_ok, out_of_range, last_word;
  logic [63:0]    redirect_aligned;

  always_comb begin
    enq              = (state == RUN) && !bus.redirect && ((cnt < FULL_C) || bus.deq);
    deq_ok           = bus.deq && (cnt != '0) && !bus.redirect;
    out_of_range     = |bus.redirect_pc[63:AW+2];
    last_word        = (fetch_pc == LAST_PC);
    redirect_aligned = bus.redirect_pc & ~64'd3;
  end

  always_comb begin
    state_nxt = state;
    if (bus.redirect) begin
      // An unreachable target parks the FSM, whatever state it came from.
      if (out_of_range)        state_nxt = DONE;
      else if (state == IDLE)  state_nxt = IDLE;
      else                     state_nxt = RUN;
    end else begin
      case (state)
        IDLE:    if (bus.enable) state_nxt = RUN;
        RUN: begin
          if (enq && last_word)  state_nxt = DONE;
          else if (!bus.enable)  state_nxt = IDLE;
        end
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= '0;
      head     <= '0;
      tail     <= '0;
      cnt      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= '0;
      end
    end else if (bus.redirect) begin
      // Flush: stale storage stays, only the pointers collapse.
      fetch_pc <= redirect_aligned;
      head     <= tail;
      cnt      <= '0;
    end else begin
      if (enq) begin
        mem_instr[tail] <= bus.imem_q;
        mem_pc[tail]    <= fetch_pc;
        tail            <= tail + 1'b1;
        fetch_pc        <= fetch_pc + 64'd4;
      end
      if (deq_ok) head <= head + 1'b1;
      if (enq && !deq_ok)      cnt <= cnt + 1'b1;
      else if (!enq && deq_ok) cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    bus.imem_addr   = fetch_pc[AW+1:2];
    bus.instr_valid = (cnt != '0);
    bus.instr       = mem_instr[head];
    bus.instr_pc    = mem_pc[head];
    bus.count       = cnt;
    bus.done        = (state == DONE);
    bus.fsm_state   = state;
  end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_imem_fetch_ctrl;
  localparam int N     = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 6;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  imem_fetch_ctrl_if #(.N(N), .DEPTH(DEPTH), .AW(AW)) bus ();

  imem_fetch_ctrl #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: word i = 0xf8000000 + (i << 15) + i
  logic [31:0] rom [64];
  initial for (int i = 0; i < 64; i++) rom[i] = 32'hf800_0000 + (i << 15) + i;
  always_comb bus.imem_q = rom[bus.imem_addr];

  // reference model
  logic [95:0] exp_q[$];
  logic [63:0] m_pc = '0;
  int          m_mode = 0;       // 0 idle, 1 fetching, 2 finished
  bit          m_fresh = 1'b1;   // storage still all-zero since reset

  task automatic model_step();
    bit pop, push;
    if (!reset) begin
      exp_q.delete();
      m_pc = '0;
      m_mode = 0;
      m_fresh = 1'b1;
    end else if (bus.redirect) begin
      exp_q.delete();
      m_pc = {bus.redirect_pc[63:2], 2'b00};
      if (bus.redirect_pc >= 64'h100) m_mode = 2;
      else if (m_mode != 0)           m_mode = 1;
    end else begin
      pop  = bus.deq && (exp_q.size() > 0);
      push = (m_mode == 1) && ((exp_q.size() < DEPTH) || bus.deq);
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        exp_q.push_back({rom[m_pc[7:2]], m_pc});
        m_fresh = 1'b0;
      end
      if (push && m_pc == 64'd252)        m_mode = 2;
      else if (m_mode == 1 && !bus.enable) m_mode = 0;
      else if (m_mode == 0 && bus.enable)  m_mode = 1;
      if (push) m_pc = m_pc + 64'd4;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    model_step();
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare, every cycle on the falling edge
  initial forever begin
    @(negedge clk);
    check("m_count", 64'(bus.count), 64'(exp_q.size()));
    check("m_valid", 64'(bus.instr_valid), 64'(exp_q.size() != 0));
    check("m_addr",  64'(bus.imem_addr), 64'(m_pc[7:2]));
    check("m_done",  64'(bus.done), 64'(m_mode == 2));
    if (exp_q.size() != 0) begin
      check("m_instr", 64'(bus.instr), 64'(exp_q[0][95:64]));
      check("m_pc",    bus.instr_pc, exp_q[0][63:0]);
    end else if (m_fresh) begin
      check("m_instr0", 64'(bus.instr), 64'd0);
      check("m_pc0",    bus.instr_pc, 64'd0);
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit en, input bit rd, input logic [63:0] rpc, input bit dq);
    bus.enable      = en;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.deq         = dq;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 64'd0, 0);
    step(2);
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_addr",  64'(bus.imem_addr), 64'd0);
    reset = 1'b1;

    // fill and stall
    drive(1, 0, 64'd0, 0);
    step(6);
    check("fill_count", 64'(bus.count), 64'd4);
    check("fill_instr", 64'(bus.instr), 64'hf800_0000);
    check("fill_pc",    bus.instr_pc, 64'd0);
    check("fill_addr",  64'(bus.imem_addr), 64'd4);
    step(3);
    check("stall_addr", 64'(bus.imem_addr), 64'd4);

    // streaming
    drive(1, 0, 64'd0, 1);
    for (int k = 0; k < 8; k++) begin
      check("stream_pc",    bus.instr_pc, 64'(4 * k));
      check("stream_count", 64'(bus.count), 64'd4);
      step(1);
    end

    // misaligned redirect with three entries queued
    drive(1, 1, 64'd0, 0);
    step(1);
    drive(1, 0, 64'd0, 0);
    step(3);
    check("pre_redir_count", 64'(bus.count), 64'd3);
    drive(1, 1, 64'h4E, 0);
    step(1);
    check("redir_count", 64'(bus.count), 64'd0);
    check("redir_valid", 64'(bus.instr_valid), 64'd0);
    check("redir_addr",  64'(bus.imem_addr), 64'd19);
    drive(1, 0, 64'd0, 0);
    step(1);
    check("redir_pc",    bus.instr_pc, 64'h4C);
    check("redir_instr", 64'(bus.instr), 64'hf809_8013);

    // end of ROM
    drive(1, 1, 64'hF8, 1);
    step(1);
    drive(1, 0, 64'd0, 1);
    step(2);
    check("eor_pc",   bus.instr_pc, 64'hFC);
    check("eor_done", 64'(bus.done), 64'd1);
    step(3);
    check("eor_count", 64'(bus.count), 64'd0);
    check("eor_hold",  64'(bus.done), 64'd1);
    drive(1, 1, 64'd0, 0);
    step(1);
    check("eor_rerun", 64'(bus.done), 64'd0);

    // out-of-range redirect
    drive(1, 1, 64'h100, 0);
    step(1);
    check("oor_done",  64'(bus.done), 64'd1);
    check("oor_count", 64'(bus.count), 64'd0);
    drive(1, 0, 64'd0, 0);
    step(2);
    check("oor_stay", 64'(bus.count), 64'd0);

    // pause: second entry is fetched on the cycle enable drops, then frozen
    drive(1, 1, 64'h20, 0);
    step(1);
    drive(1, 0, 64'd0, 0);
    step(1);
    drive(0, 0, 64'd0, 0);
    step(1);
    step(3);
    check("pause_count", 64'(bus.count), 64'd2);
    check("pause_addr",  64'(bus.imem_addr), 64'd10);
    check("pause_pc",    bus.instr_pc, 64'h20);
    drive(0, 0, 64'd0, 1);
    step(1);
    check("drain_pc",    bus.instr_pc, 64'h24);
    step(1);
    check("drain_count", 64'(bus.count), 64'd0);

    // asynchronous reset mid-run
    drive(1, 0, 64'd0, 0);
    step(4);
    check("pre_rst_valid", 64'(bus.instr_valid), 64'd1);
    #1 reset = 1'b0;
    #1;
    check("arst_count", 64'(bus.count), 64'd0);
    check("arst_valid", 64'(bus.instr_valid), 64'd0);
    check("arst_addr",  64'(bus.imem_addr), 64'd0);
    step(2);
    reset = 1'b1;
    step(2);
    check("resume_valid", 64'(bus.instr_valid), 64'd1);
    check("resume_pc",    bus.instr_pc, 64'd0);
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
